// File: rtl/pmod_rx_frame_if.sv
// Bus bundle for pmod_rx_frame: the remote handshake and serial line in, the received frame out.
// The slave modport belongs to the receiver and the master modport to whatever drives it.
interface pmod_rx_frame_if #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128
);
  logic              enable;
  logic              RxD;
  logic              r_sync;
  logic              r_acknowledge;
  logic              frame_ack;
  logic [DATA_W-1:0] data_out;
  logic [KEY_W-1:0]  key_out;
  logic              encrypt;
  logic              frame_valid;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  enable, RxD, r_sync, r_acknowledge, frame_ack,
    output data_out, key_out, encrypt, frame_valid, frame_err, busy
  );

  modport master (
    output enable, RxD, r_sync, r_acknowledge, frame_ack,
    input  data_out, key_out, encrypt, frame_valid, frame_err, busy
  );
endinterface

// File: rtl/pmod_rx_frame.sv
// Serial frame receiver: mode bit, DATA_W data bits, KEY_W key bits, MSB first, one bit per acked clk.
// Define RX_PARITY_EN to add a trailing even-parity bit over mode+data+key.
module pmod_rx_frame #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128
) (
  input  logic           clk,
  input  logic           reset_b,
  pmod_rx_frame_if.slave bus
);

  localparam int MAX_W = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_MODE,
    S_DATA,
    S_KEY,
`ifdef RX_PARITY_EN
    S_PAR,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode_sh;
  logic [DATA_W-1:0] r_data_sh;
  logic [KEY_W-1:0]  r_key_sh;
`ifdef RX_PARITY_EN
  logic              r_par;
`endif
  logic [DATA_W-1:0] r_data_out;
  logic [KEY_W-1:0]  r_key_out;
  logic              r_encrypt;
  logic              r_frame_valid;
  logic              r_frame_err;
  logic              r_busy;

  logic [DATA_W-1:0] w_data_next;
  logic [KEY_W-1:0]  w_key_next;
  logic              w_final_state;

  assign w_data_next = {r_data_sh[DATA_W-2:0], bus.RxD};
  assign w_key_next  = {r_key_sh[KEY_W-2:0], bus.RxD};

  // The state whose next sampled bit completes the frame; a frame_ack on that bit is ignored.
`ifdef RX_PARITY_EN
  assign w_final_state = (r_state == S_PAR);
`else
  assign w_final_state = (r_state == S_KEY) && (r_cnt == KEY_LAST);
`endif

  assign bus.data_out    = r_data_out;
  assign bus.key_out     = r_key_out;
  assign bus.encrypt     = r_encrypt;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mode_sh     <= 1'b0;
      r_data_sh     <= '0;
      r_key_sh      <= '0;
`ifdef RX_PARITY_EN
      r_par         <= 1'b0;
`endif
      r_data_out    <= '0;
      r_key_out     <= '0;
      r_encrypt     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else if (bus.enable) begin
      case (r_state)
        S_IDLE: begin
          if (bus.frame_ack) r_frame_err <= 1'b0;
          if (bus.r_sync && !bus.r_acknowledge) begin
            r_state <= S_ARMED;
            r_busy  <= 1'b1;
          end
        end

        S_ARMED: begin
          if (bus.frame_ack) r_frame_err <= 1'b0;
          if (!bus.r_sync) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.r_acknowledge) begin
            r_state <= S_MODE;
            r_cnt   <= '0;
          end
        end

        S_DONE: begin
          if (bus.frame_ack) begin
            r_state       <= S_IDLE;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
          end else if (bus.r_sync && bus.r_acknowledge) begin
            r_frame_err <= 1'b1;
          end
        end

        // Receiving states: losing r_sync aborts without touching the visible frame.
        default: begin
          if (!bus.r_sync) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
          end else begin
            if (bus.frame_ack && !(bus.r_acknowledge && w_final_state)) r_frame_err <= 1'b0;
            if (bus.r_acknowledge) begin
              case (r_state)
                S_MODE: begin
                  r_mode_sh <= bus.RxD;
`ifdef RX_PARITY_EN
                  r_par     <= bus.RxD;
`endif
                  r_cnt     <= '0;
                  r_state   <= S_DATA;
                end

                S_DATA: begin
                  r_data_sh <= w_data_next;
`ifdef RX_PARITY_EN
                  r_par     <= r_par ^ bus.RxD;
`endif
                  if (r_cnt == DATA_LAST) begin
                    r_cnt   <= '0;
                    r_state <= S_KEY;
                  end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                  end
                end

                S_KEY: begin
                  r_key_sh <= w_key_next;
`ifdef RX_PARITY_EN
                  r_par    <= r_par ^ bus.RxD;
`endif
                  if (r_cnt == KEY_LAST) begin
                    r_cnt <= '0;
`ifdef RX_PARITY_EN
                    r_state <= S_PAR;
`else
                    r_data_out    <= r_data_sh;
                    r_key_out     <= w_key_next;
                    r_encrypt     <= r_mode_sh;
                    r_frame_valid <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_DONE;
`endif
                  end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                  end
                end

`ifdef RX_PARITY_EN
                // A parity mismatch still delivers the frame, flagged through frame_err.
                S_PAR: begin
                  r_data_out    <= r_data_sh;
                  r_key_out     <= r_key_sh;
                  r_encrypt     <= r_mode_sh;
                  r_frame_valid <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_DONE;
                  if (r_par ^ bus.RxD) r_frame_err <= 1'b1;
                end
`endif

                default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_rx_frame.sv
// Directed + randomized bench for pmod_rx_frame; expected outputs come from the fields the bench sent.
module tb_pmod_rx_frame;
  localparam int DW = 128;
  localparam int KW = 128;
`ifdef RX_PARITY_EN
  localparam int FRAME = 1 + DW + KW + 1;
`else
  localparam int FRAME = 1 + DW + KW;
`endif

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  pmod_rx_frame_if #(.DATA_W(DW), .KEY_W(KW)) bus ();
  pmod_rx_frame #(.DATA_W(DW), .KEY_W(KW)) dut (.clk(clk), .reset_b(reset_b), .bus(bus));

  int total = 0;
  int bad   = 0;
  int edgeCount = 0;

  logic [DW-1:0] expData;
  logic [KW-1:0] expKey;
  logic          expEnc;
  logic          expValid;
  logic          expErr;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic expBusy);
    checkOutput({tag, "/data"},  bus.data_out, expData);
    checkOutput({tag, "/key"},   bus.key_out, expKey);
    checkOutput({tag, "/enc"},   128'(bus.encrypt), 128'(expEnc));
    checkOutput({tag, "/valid"}, 128'(bus.frame_valid), 128'(expValid));
    checkOutput({tag, "/err"},   128'(bus.frame_err), 128'(expErr));
    checkOutput({tag, "/busy"},  128'(bus.busy), 128'(expBusy));
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
    edgeCount++;
  endtask

  task automatic applyStimulus(input logic sync, input logic ack, input logic rxd);
    bus.r_sync        = sync;
    bus.r_acknowledge = ack;
    bus.RxD           = rxd;
    stepClk();
  endtask

  function automatic logic [FRAME-1:0] buildFrame(input logic m, input logic [DW-1:0] d,
                                                  input logic [KW-1:0] k);
`ifdef RX_PARITY_EN
    logic p;
    p = ^{m, d, k};
    return {m, d, k, p};
`else
    return {m, d, k};
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("armedBusy", 128'(bus.busy), 128'(1));
    applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  // Full frame with nStall stall cycles scattered before data bits; lat = handshake edge to frame_valid.
  task automatic sendFrame(input logic m, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input int nStall, input bit stallByEnable, input bit badPar,
                           input bit ackOnLast, output int lat);
    logic [FRAME-1:0] fb;
    int stallCnt[FRAME];
    int t0;
    int tValid;
    fb = buildFrame(m, d, k);
`ifdef RX_PARITY_EN
    if (badPar) fb[0] = ~fb[0];
`endif
    foreach (stallCnt[i]) stallCnt[i] = 0;
    repeat (nStall) stallCnt[$urandom_range(DW, 2)]++;
    startFrame();
    t0 = edgeCount;
    tValid = -1;
    for (int i = 0; i < FRAME; i++) begin
      for (int s = 0; s < stallCnt[i]; s++) begin
        if (stallByEnable && ($urandom_range(1, 0) == 1)) bus.enable = 1'b0;
        else bus.r_acknowledge = 1'b0;
        bus.RxD = 1'($urandom_range(1, 0));
        stepClk();
        if (bus.frame_valid && tValid < 0) tValid = edgeCount;
        bus.enable = 1'b1;
        bus.r_acknowledge = 1'b1;
      end
      bus.frame_ack = ackOnLast && (i == FRAME - 1);
      applyStimulus(1'b1, 1'b1, fb[FRAME-1-i]);
      if (bus.frame_valid && tValid < 0) tValid = edgeCount;
    end
    bus.frame_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    lat = (tValid < 0) ? -1 : tValid - t0;
    expData  = d;
    expKey   = k;
    expEnc   = m;
    expValid = 1'b1;
    expErr   = expErr | badPar;
  endtask

  task automatic sendPartial(input int nBits, input logic m, input logic [DW-1:0] d,
                             input logic [KW-1:0] k);
    logic [FRAME-1:0] fb;
    fb = buildFrame(m, d, k);
    startFrame();
    for (int i = 0; i < nBits; i++) applyStimulus(1'b1, 1'b1, fb[FRAME-1-i]);
  endtask

  task automatic ackFrame();
    bus.frame_ack = 1'b1;
    stepClk();
    bus.frame_ack = 1'b0;
    expValid = 1'b0;
    expErr   = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          m;
    int            lat;
    int            base;
    int            ns;

    reset_b = 1'b1;
    bus.enable = 1'b1;
    bus.RxD = 1'b0;
    bus.r_sync = 1'b0;
    bus.r_acknowledge = 1'b0;
    bus.frame_ack = 1'b0;
    expData = '0;
    expKey = '0;
    expEnc = 1'b0;
    expValid = 1'b0;
    expErr = 1'b0;
    $display("[TB] start, frame length %0d bits", FRAME);

    stepClk();
    stepClk();
    checkAll("reset", 1'b0);
    reset_b = 1'b0;
    stepClk();

    // Reference frame, no stalls
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    k = '1;
    sendFrame(1'b1, d, k, 0, 1'b0, 1'b0, 1'b0, lat);
    base = lat;
    checkAll("frame1", 1'b0);
    checkOutput("frame1/lat", 128'(lat), 128'(FRAME));
    ackFrame();
    checkAll("ack1", 1'b0);

    // Same frame, five ack-low stalls in the data field
    sendFrame(1'b1, d, k, 5, 1'b0, 1'b0, 1'b0, lat);
    checkAll("stall5", 1'b0);
    checkOutput("stall5/lat", 128'(lat), 128'(base + 5));
    ackFrame();

    // Abort after mode + 40 data bits leaves the previous frame visible
    sendPartial(41, 1'b0, rand128(), rand128());
    applyStimulus(1'b0, 1'b0, 1'b0);
    expErr = 1'b1;
    checkAll("abort40", 1'b0);
    bus.frame_ack = 1'b1;
    stepClk();
    bus.frame_ack = 1'b0;
    expErr = 1'b0;
    checkAll("idleAck", 1'b0);

    // Random frames with mixed ack/enable stalls
    for (int n = 0; n < 3; n++) begin
      m = 1'($urandom_range(1, 0));
      d = rand128();
      k = rand128();
      ns = $urandom_range(6, 0);
      sendFrame(m, d, k, ns, 1'b1, 1'b0, 1'b0, lat);
      checkAll("rand", 1'b0);
      checkOutput("rand/lat", 128'(lat), 128'(FRAME + ns));
      ackFrame();
    end

    // Overrun: bits arriving while the frame is still unacknowledged
    m = 1'b0;
    d = rand128();
    k = rand128();
    sendFrame(m, d, k, 0, 1'b0, 1'b0, 1'b0, lat);
    checkAll("preOverrun", 1'b0);
    bus.r_sync = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'($urandom_range(1, 0)));
    applyStimulus(1'b0, 1'b0, 1'b0);
    expErr = 1'b1;
    checkAll("overrun", 1'b0);
    ackFrame();
    checkAll("overrunAck", 1'b0);

    // Abort in the key field, then a frame_ack on the final bit must be ignored
    sendPartial($urandom_range(FRAME - 1, DW + 2), 1'b1, rand128(), rand128());
    applyStimulus(1'b0, 1'b0, 1'b0);
    expErr = 1'b1;
    checkAll("abortKey", 1'b0);
    m = 1'b1;
    d = rand128();
    k = rand128();
    sendFrame(m, d, k, 0, 1'b0, 1'b0, 1'b1, lat);
    checkAll("ackOnLast", 1'b0);
    ackFrame();
    checkAll("ackOnLastClr", 1'b0);

    // Reset during key bit 10, then a clean frame
    sendPartial(1 + DW + 10, 1'b1, rand128(), rand128());
    reset_b = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    expData = '0;
    expKey = '0;
    expEnc = 1'b0;
    expValid = 1'b0;
    expErr = 1'b0;
    checkAll("midReset", 1'b0);
    reset_b = 1'b0;
    stepClk();
    m = 1'b1;
    d = rand128();
    k = rand128();
    sendFrame(m, d, k, 2, 1'b1, 1'b0, 1'b0, lat);
    checkAll("postReset", 1'b0);
    checkOutput("postReset/lat", 128'(lat), 128'(FRAME + 2));
    ackFrame();

`ifdef RX_PARITY_EN
    // Wrong parity still delivers the frame, flagged as an error
    sendFrame(1'b0, rand128(), rand128(), 0, 1'b0, 1'b1, 1'b0, lat);
    checkAll("badParity", 1'b0);
    ackFrame();
    checkAll("badParityAck", 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmod_rx_frame.md
PMOD_RX_FRAME -- requirements
Module: pmod_rx_frame

Interface
REQ-001 Parameter DATA_W, default 128, width of the received data field.
REQ-002 Parameter KEY_W, default 128, width of the received key field.
REQ-003 clk  input  1  system clock; one clock only.
REQ-004 reset_b  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  receiver enable; when low, the FSM holds state and no bit is sampled.
REQ-006 RxD  input  1  serial data line, one bit sampled per clk.
REQ-007 r_sync  input  1  remote device requests a transfer.
REQ-008 r_acknowledge  input  1  handshake complete; each clk with r_sync&r_acknowledge carries one bit.
REQ-009 frame_ack  input  1  consumer has taken the frame; clears frame_valid.
REQ-010 data_out  output  DATA_W  last complete data field, MSB received first.
REQ-011 key_out  output  KEY_W  last complete key field, MSB received first.
REQ-012 encrypt  output  1  mode bit of the last complete frame.
REQ-013 frame_valid  output  1  complete frame held on outputs, level until frame_ack.
REQ-014 frame_err  output  1  sticky: the last frame aborted or overran (or failed parity); cleared by frame_ack or reset.
REQ-015 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-016 Frame = 1 mode bit, then DATA_W data bits, then KEY_W key bits; with RX_PARITY_EN, 1 parity bit follows.
REQ-017 States: IDLE, ARMED, MODE, DATA, KEY, PAR (RX_PARITY_EN only), DONE.
REQ-018 IDLE->ARMED when enable&r_sync&~r_acknowledge.
REQ-019 ARMED->MODE when r_sync&r_acknowledge; ARMED->IDLE when r_sync drops.
REQ-020 In MODE, DATA, KEY and PAR, one bit is sampled on each clk with enable&r_sync&r_acknowledge; cycles without r_acknowledge are stalls; no bit is sampled and the counter holds.
REQ-021 MODE samples the mode bit into a shadow register; next state is DATA.
REQ-022 DATA shifts bits into a DATA_W shadow shift register; a bit counter of width $clog2(max(DATA_W,KEY_W)+1) moves to KEY after DATA_W bits.
REQ-023 KEY shifts into a KEY_W shadow register; it moves to PAR (or to DONE without the macro) after KEY_W bits.
REQ-024 On entry to DONE, the shadow registers are copied to data_out, key_out and encrypt in one cycle; frame_valid rises the clk after the last bit is sampled.
REQ-025 The outputs hold the previous frame during reception and never show partial data.
REQ-026 r_sync low in MODE, DATA, KEY or PAR aborts: the FSM returns to IDLE, frame_err is set, the outputs are unchanged and frame_valid is not asserted.
REQ-027 DONE->IDLE on frame_ack; frame_valid and frame_err clear on that cycle.
REQ-028 In DONE, r_sync&r_acknowledge sets frame_err (overrun); those bits are discarded.
REQ-029 frame_ack outside DONE clears only frame_err.
REQ-030 A frame_ack in the same cycle as the final sampled bit is ignored.

Reset
REQ-031 reset_b high at a clk edge forces IDLE, a zero counter, zero shadow registers, data_out=0, key_out=0, encrypt=0, frame_valid=0, frame_err=0 and busy=0.
REQ-032 Reset mid-frame discards all partial bits, and no output pulse results.

Configuration
REQ-033 Macro RX_PARITY_EN defined: the PAR state exists; the frame carries a trailing even-parity bit over mode+data+key.
REQ-034 With RX_PARITY_EN, a mismatch still loads the outputs and raises frame_valid, and frame_err is set in the same cycle.
REQ-035 RX_PARITY_EN undefined: no PAR state and no parity logic; the frame is 1+DATA_W+KEY_W bits and frame_err reports only abort and overrun.

Verification
REQ-036 DATA_W=KEY_W=128, sync, ack, then mode=1, data=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, key=all-ones -> outputs match, frame_valid one clk after bit 257, frame_err=0.
REQ-037 Same frame with r_acknowledge low for 5 random mid-data cycles -> identical outputs, frame_valid delayed by exactly 5 clk.
REQ-038 r_sync dropped after 40 data bits -> IDLE, frame_err=1, frame_valid=0, previous data_out unchanged.
REQ-039 Frame complete, no frame_ack, second sync&ack burst -> frame_err=1, data_out keeps the first frame; frame_ack -> both flags 0, IDLE.
REQ-040 DATA_W=8, KEY_W=16, RX_PARITY_EN, data=0xA5, key=0x1234, mode=0, wrong parity -> outputs loaded, frame_valid=1, frame_err=1.
REQ-041 reset_b pulsed at key bit 10 -> all outputs 0 the next clk; a following full frame is received correctly.
